// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs and datapath widths.
package y86_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned ICODE_W  = 4;
  localparam int unsigned NUM_REGS = 15;
  localparam int unsigned CNT_W    = 32;

  localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
  localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
  localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

  localparam logic [REG_W-1:0] REG_RSP  = 4'h4;
  localparam logic [REG_W-1:0] REG_NONE = 4'hF;

endpackage

// File: rtl/decode_regfile_reg_array.sv
// 15x64 program register storage: two write ports (M overrides E on the same ID) and
// three read ports; ID F never stores and always reads as zero.
module reg_array
  import y86_pkg::*;
#(
  parameter logic [WORD_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_e_i,
  input  logic [REG_W-1:0]  waddr_e_i,
  input  logic [WORD_W-1:0] wdata_e_i,
  input  logic              we_m_i,
  input  logic [REG_W-1:0]  waddr_m_i,
  input  logic [WORD_W-1:0] wdata_m_i,
  input  logic [REG_W-1:0]  raddr_a_i,
  output logic [WORD_W-1:0] rdata_a_o,
  input  logic [REG_W-1:0]  raddr_b_i,
  output logic [WORD_W-1:0] rdata_b_o,
  input  logic [REG_W-1:0]  raddr_d_i,
  output logic [WORD_W-1:0] rdata_d_o
);

  logic [WORD_W-1:0] regs_q [NUM_REGS];

  // M port is written last so it wins when both ports target the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (REG_W'(i) == REG_RSP) ? RSP_INIT : '0;
      end
    end else begin
      if (we_e_i && (waddr_e_i != REG_NONE)) regs_q[waddr_e_i] <= wdata_e_i;
      if (we_m_i && (waddr_m_i != REG_NONE)) regs_q[waddr_m_i] <= wdata_m_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == REG_NONE) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == REG_NONE) ? '0 : regs_q[raddr_b_i];
  assign rdata_d_o = (raddr_d_i == REG_NONE) ? '0 : regs_q[raddr_d_i];

endmodule

// File: rtl/decode_regfile.sv
// SEQ decode/write-back register file: source/destination selection, optional
// write-to-read forwarding and a count of cycles that committed a write.
module decode_regfile
  import y86_pkg::*;
#(
  parameter logic [WORD_W-1:0] RSP_INIT = '0,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ICODE_W-1:0] icode,
  input  logic [REG_W-1:0]   rA,
  input  logic [REG_W-1:0]   rB,
  output logic [REG_W-1:0]   srcA,
  output logic [REG_W-1:0]   srcB,
  output logic [WORD_W-1:0]  valA,
  output logic [WORD_W-1:0]  valB,
  input  logic               wb_en,
  input  logic [ICODE_W-1:0] wb_icode,
  input  logic [REG_W-1:0]   wb_rA,
  input  logic [REG_W-1:0]   wb_rB,
  input  logic               wb_cnd,
  input  logic [WORD_W-1:0]  valE,
  input  logic [WORD_W-1:0]  valM,
  output logic [REG_W-1:0]   dstE,
  output logic [REG_W-1:0]   dstM,
  input  logic [REG_W-1:0]   dbg_addr,
  output logic [WORD_W-1:0]  dbg_data,
  output logic [CNT_W-1:0]   wb_count
);

  logic              we_e, we_m;
  logic [WORD_W-1:0] rd_a, rd_b;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;

  always_comb begin
    srcA = REG_NONE;
    srcB = REG_NONE;
    unique case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
      I_RET, I_POPQ:                      srcA = REG_RSP;
      default: ;
    endcase
    unique case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = REG_RSP;
      default: ;
    endcase
  end

  // cmovXX only targets rB when its condition held
  always_comb begin
    dstE = REG_NONE;
    dstM = REG_NONE;
    unique case (wb_icode)
      I_RRMOVQ:                           dstE = wb_cnd ? wb_rB : REG_NONE;
      I_IRMOVQ, I_OPQ:                    dstE = wb_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = REG_RSP;
      default: ;
    endcase
    unique case (wb_icode)
      I_MRMOVQ, I_POPQ:                   dstM = wb_rA;
      default: ;
    endcase
  end

  assign we_e = wb_en && (dstE != REG_NONE);
  assign we_m = wb_en && (dstM != REG_NONE);

  reg_array #(
    .RSP_INIT (RSP_INIT)
  ) u_reg_array (
    .clk       (clk),
    .rst       (rst),
    .we_e_i    (we_e),
    .waddr_e_i (dstE),
    .wdata_e_i (valE),
    .we_m_i    (we_m),
    .waddr_m_i (dstM),
    .wdata_m_i (valM),
    .raddr_a_i (srcA),
    .rdata_a_o (rd_a),
    .raddr_b_i (srcB),
    .rdata_b_o (rd_b),
    .raddr_d_i (dbg_addr),
    .rdata_d_o (dbg_data)
  );

  // Forwarding: M data beats E data, mirroring the commit priority
  always_comb begin
    valA = rd_a;
    valB = rd_b;
    if (BYPASS) begin
      if (we_m && (srcA == dstM))      valA = valM;
      else if (we_e && (srcA == dstE)) valA = valE;
      if (we_m && (srcB == dstM))      valB = valM;
      else if (we_e && (srcB == dstE)) valB = valE;
    end
  end

  assign wb_count_d = wb_count_q + CNT_W'(we_e || we_m);

  always_ff @(posedge clk) begin
    if (rst) wb_count_q <= '0;
    else     wb_count_q <= wb_count_d;
  end

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboard bench for decode_regfile: a forwarding and a non-forwarding instance share
// all inputs so both views of each write-back cycle can be checked side by side.
module tb_decode_regfile;
  import y86_pkg::*;

  localparam logic [63:0] RSP_RST = 64'h0000_0000_0000_F000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB, wb_icode, wb_rA, wb_rB, dbg_addr;
  logic        wb_en, wb_cnd;
  logic [63:0] valE, valM;

  logic [3:0]  srcA_b, srcB_b, dstE_b, dstM_b, srcA_n, srcB_n, dstE_n, dstM_n;
  logic [63:0] valA_b, valB_b, dbg_b, valA_n, valB_n, dbg_n;
  logic [31:0] wbc_b, wbc_n;

  logic [63:0] exp_q[$];
  logic [63:0] e;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  decode_regfile #(.RSP_INIT(RSP_RST), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
    .srcA(srcA_b), .srcB(srcB_b), .valA(valA_b), .valB(valB_b),
    .wb_en(wb_en), .wb_icode(wb_icode), .wb_rA(wb_rA), .wb_rB(wb_rB), .wb_cnd(wb_cnd),
    .valE(valE), .valM(valM), .dstE(dstE_b), .dstM(dstM_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wb_count(wbc_b)
  );

  decode_regfile #(.RSP_INIT(RSP_RST), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
    .srcA(srcA_n), .srcB(srcB_n), .valA(valA_n), .valB(valB_n),
    .wb_en(wb_en), .wb_icode(wb_icode), .wb_rA(wb_rA), .wb_rB(wb_rB), .wb_cnd(wb_cnd),
    .valE(valE), .valM(valM), .dstE(dstE_n), .dstM(dstM_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wb_count(wbc_n)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_en = 1'b0; wb_cnd = 1'b0;
    icode = I_HALT; rA = 4'h0; rB = 4'h0;
    wb_icode = I_HALT; wb_rA = 4'hF; wb_rB = 4'hF; valE = '0; valM = '0; dbg_addr = 4'h4;
    next_cycle(); next_cycle();
    rst = 1'b0;
    exp_q.push_back(RSP_RST); exp_q.push_back(64'd0); exp_q.push_back(64'hF);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL reset_rsp: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL reset_count: got %h expected %h", wbc_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(srcA_b) !== e) begin n_bad++; $display("FAIL reset_srcA_halt: got %h expected %h", srcA_b, e); end
    dbg_addr = 4'hE; exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL reset_r14: got %h expected %h", dbg_b, e); end
    dbg_addr = 4'hF; exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL reset_dbgF: got %h expected %h", dbg_b, e); end
  endtask

  task automatic test_irmovq();
    wb_en = 1'b1; wb_icode = I_IRMOVQ; wb_rA = 4'hF; wb_rB = 4'h2; valE = 64'h1234;
    icode = I_OPQ; rA = 4'h0; rB = 4'h2;
    exp_q.push_back(64'h2); exp_q.push_back(64'hF);
    exp_q.push_back(64'h1234); exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstE_b) !== e) begin n_bad++; $display("FAIL irmovq_dstE: got %h expected %h", dstE_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstM_b) !== e) begin n_bad++; $display("FAIL irmovq_dstM: got %h expected %h", dstM_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valB_b !== e) begin n_bad++; $display("FAIL irmovq_fwd_valB: got %h expected %h", valB_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valB_n !== e) begin n_bad++; $display("FAIL irmovq_old_valB: got %h expected %h", valB_n, e); end
    next_cycle();
    wb_en = 1'b0;
    exp_q.push_back(64'h2); exp_q.push_back(64'h1234); exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (64'(srcB_n) !== e) begin n_bad++; $display("FAIL irmovq_srcB: got %h expected %h", srcB_n, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valB_n !== e) begin n_bad++; $display("FAIL irmovq_valB: got %h expected %h", valB_n, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL irmovq_count: got %h expected %h", wbc_b, e); end
  endtask

  task automatic test_popq_rsp();
    wb_en = 1'b1; wb_icode = I_POPQ; wb_rA = 4'h4; wb_rB = 4'hF;
    valE = 64'h108; valM = 64'hABCD; icode = I_RET;
    exp_q.push_back(64'h4); exp_q.push_back(64'h4);
    exp_q.push_back(64'hABCD); exp_q.push_back(RSP_RST);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstE_b) !== e) begin n_bad++; $display("FAIL popq_dstE: got %h expected %h", dstE_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstM_b) !== e) begin n_bad++; $display("FAIL popq_dstM: got %h expected %h", dstM_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valA_b !== e) begin n_bad++; $display("FAIL popq_fwd_M_prio: got %h expected %h", valA_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valA_n !== e) begin n_bad++; $display("FAIL popq_old_valA: got %h expected %h", valA_n, e); end
    next_cycle();
    wb_en = 1'b0; dbg_addr = 4'h4;
    exp_q.push_back(64'hABCD); exp_q.push_back(64'd2);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL popq_rsp: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL popq_count: got %h expected %h", wbc_b, e); end
  endtask

  task automatic test_cmov();
    wb_en = 1'b1; wb_icode = I_RRMOVQ; wb_cnd = 1'b0; wb_rA = 4'h1; wb_rB = 4'h3; valE = 64'd5;
    exp_q.push_back(64'hF); exp_q.push_back(64'hF);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstE_b) !== e) begin n_bad++; $display("FAIL cmov_nt_dstE: got %h expected %h", dstE_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstM_b) !== e) begin n_bad++; $display("FAIL cmov_nt_dstM: got %h expected %h", dstM_b, e); end
    next_cycle();
    wb_en = 1'b0; dbg_addr = 4'h3;
    exp_q.push_back(64'd0); exp_q.push_back(64'd2);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL cmov_nt_r3: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL cmov_nt_count: got %h expected %h", wbc_b, e); end
    wb_en = 1'b1; wb_cnd = 1'b1;
    exp_q.push_back(64'h3);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstE_b) !== e) begin n_bad++; $display("FAIL cmov_t_dstE: got %h expected %h", dstE_b, e); end
    next_cycle();
    wb_en = 1'b0; wb_cnd = 1'b0;
    exp_q.push_back(64'd5); exp_q.push_back(64'd3);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL cmov_t_r3: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL cmov_t_count: got %h expected %h", wbc_b, e); end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_icode = I_IRMOVQ; wb_rB = 4'h7; valE = 64'h33; icode = I_HALT;
    next_cycle();
    valE = 64'd9; icode = I_OPQ; rA = 4'h7; rB = 4'h7;
    exp_q.push_back(64'd9); exp_q.push_back(64'h33); exp_q.push_back(64'd9); exp_q.push_back(64'h33);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (valB_b !== e) begin n_bad++; $display("FAIL bypass_valB_fwd: got %h expected %h", valB_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valB_n !== e) begin n_bad++; $display("FAIL bypass_valB_nofwd: got %h expected %h", valB_n, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valA_b !== e) begin n_bad++; $display("FAIL bypass_valA_fwd: got %h expected %h", valA_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valA_n !== e) begin n_bad++; $display("FAIL bypass_valA_nofwd: got %h expected %h", valA_n, e); end
    next_cycle();
    wb_en = 1'b0;
    exp_q.push_back(64'd9); exp_q.push_back(64'd5);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (valB_n !== e) begin n_bad++; $display("FAIL bypass_r7_after: got %h expected %h", valB_n, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_n) !== e) begin n_bad++; $display("FAIL bypass_count: got %h expected %h", wbc_n, e); end
  endtask

  task automatic test_ret_call();
    icode = I_RET; wb_en = 1'b1; wb_icode = I_CALL; wb_rA = 4'h2; wb_rB = 4'h2;
    valE = 64'hF8; valM = 64'h1111;
    exp_q.push_back(64'h4); exp_q.push_back(64'h4); exp_q.push_back(64'h4); exp_q.push_back(64'hF);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (64'(srcA_b) !== e) begin n_bad++; $display("FAIL ret_srcA: got %h expected %h", srcA_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(srcB_b) !== e) begin n_bad++; $display("FAIL ret_srcB: got %h expected %h", srcB_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstE_b) !== e) begin n_bad++; $display("FAIL call_dstE: got %h expected %h", dstE_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(dstM_b) !== e) begin n_bad++; $display("FAIL call_dstM: got %h expected %h", dstM_b, e); end
    next_cycle();
    wb_en = 1'b0; dbg_addr = 4'h4;
    exp_q.push_back(64'hF8); exp_q.push_back(64'hF8); exp_q.push_back(64'd6);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL call_dbg_rsp: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (valA_n !== e) begin n_bad++; $display("FAIL call_valA_rsp: got %h expected %h", valA_n, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL call_count: got %h expected %h", wbc_b, e); end
  endtask

  task automatic test_illegal();
    logic [3:0] ill [7];
    ill = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int k = 0; k < 7; k++) begin
      icode = ill[k]; rA = 4'h2; rB = 4'h2;
      wb_en = 1'b1; wb_icode = ill[k]; wb_rA = 4'h2; wb_rB = 4'h2; wb_cnd = 1'b1;
      valE = 64'hDEAD; valM = 64'hBEEF;
      exp_q.push_back(64'hF); exp_q.push_back(64'd0); exp_q.push_back(64'hF); exp_q.push_back(64'hF);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (64'(srcA_b) !== e) begin n_bad++; $display("FAIL illegal_srcA[%h]: got %h expected %h", ill[k], srcA_b, e); end
      e = exp_q.pop_front(); n_cmp++;
      if (valB_b !== e) begin n_bad++; $display("FAIL illegal_valB[%h]: got %h expected %h", ill[k], valB_b, e); end
      e = exp_q.pop_front(); n_cmp++;
      if (64'(dstE_b) !== e) begin n_bad++; $display("FAIL illegal_dstE[%h]: got %h expected %h", ill[k], dstE_b, e); end
      e = exp_q.pop_front(); n_cmp++;
      if (64'(dstM_b) !== e) begin n_bad++; $display("FAIL illegal_dstM[%h]: got %h expected %h", ill[k], dstM_b, e); end
      next_cycle();
    end
    wb_en = 1'b0; wb_cnd = 1'b0; dbg_addr = 4'h2;
    exp_q.push_back(64'h1234); exp_q.push_back(64'd6);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL illegal_r2_kept: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL illegal_count: got %h expected %h", wbc_b, e); end
  endtask

  task automatic test_wb_disabled();
    wb_en = 1'b0; wb_icode = I_IRMOVQ; wb_rB = 4'h2; valE = 64'h777;
    icode = I_OPQ; rB = 4'h2;
    exp_q.push_back(64'h1234);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (valB_b !== e) begin n_bad++; $display("FAIL disabled_no_fwd: got %h expected %h", valB_b, e); end
    next_cycle();
    dbg_addr = 4'h2;
    exp_q.push_back(64'h1234); exp_q.push_back(64'd6);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL disabled_r2: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL disabled_count: got %h expected %h", wbc_b, e); end
  endtask

  task automatic test_reset_mid_commit();
    rst = 1'b1; wb_en = 1'b1; wb_icode = I_IRMOVQ; wb_rB = 4'h1; valE = 64'd77;
    next_cycle();
    rst = 1'b0; wb_en = 1'b0; dbg_addr = 4'h1;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL rstmid_r1: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL rstmid_count: got %h expected %h", wbc_b, e); end
    dbg_addr = 4'h4;
    exp_q.push_back(RSP_RST);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL rstmid_rsp: got %h expected %h", dbg_b, e); end
    dbg_addr = 4'h7;
    exp_q.push_back(64'd0);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_n !== e) begin n_bad++; $display("FAIL rstmid_r7: got %h expected %h", dbg_n, e); end
    wb_en = 1'b1;
    next_cycle();
    wb_en = 1'b0; dbg_addr = 4'h1;
    exp_q.push_back(64'd77); exp_q.push_back(64'd1);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (dbg_b !== e) begin n_bad++; $display("FAIL rstpost_r1: got %h expected %h", dbg_b, e); end
    e = exp_q.pop_front(); n_cmp++;
    if (64'(wbc_b) !== e) begin n_bad++; $display("FAIL rstpost_count: got %h expected %h", wbc_b, e); end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_popq_rsp();
    test_cmov();
    test_bypass();
    test_ret_call();
    test_illegal();
    test_wb_disabled();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
